// File: rtl/addepreamble_if.sv
// Nibble-stream bundle between the CRC-append stage, the preamble inserter and
// the MII transmitter. The master is the upstream/driver side; the slave is the
// preamble inserter.
interface addepreamble_if;
    logic       i_ce;
    logic       i_en;
    logic       i_cancel;
    logic       i_v;
    logic [3:0] i_d;
    logic       o_v;
    logic [3:0] o_d;
    logic       o_busy;
    logic       o_drop;

    modport master (
        output i_ce, i_en, i_cancel, i_v, i_d,
        input  o_v, o_d, o_busy, o_drop
    );

    modport slave (
        input  i_ce, i_en, i_cancel, i_v, i_d,
        output o_v, o_d, o_busy, o_drop
    );
endinterface

// File: rtl/addepreamble.sv
// Ethernet TX preamble/SFD inserter with inter-frame gap enforcement.
// A 16-entry nibble delay line is preloaded with 14x 5, SFD and the first data
// nibble at frame start, so the data emerges 16 ce cycles later behind a full
// 15x 5 + D preamble. In bypass mode the input is simply registered.
module addepreamble #(
    parameter int unsigned IFG_NIBBLES = 24,
    parameter int unsigned LGIFG       = 5
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    addepreamble_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StFrame, StDrain, StGap} state_e;

    // Drain ends on the edge that emits the last valid nibble, so a full count
    // yields exactly IFG_NIBBLES idle cycles. Bypass frames end on the edge
    // where o_v already falls, so one count is removed there.
    localparam logic [LGIFG-1:0] GapFull  = LGIFG'(IFG_NIBBLES - 1);
    localparam logic [LGIFG-1:0] GapShort = LGIFG'(IFG_NIBBLES - 2);

    state_e           state_q, state_d;
    logic [15:0]      line_v_q, line_v_d;   // entry 0 is the next to be output
    logic [63:0]      line_d_q, line_d_d;
    logic             ov_q, ov_d;
    logic [3:0]       od_q, od_d;
    logic             bypass_q, bypass_d;
    logic [LGIFG-1:0] cnt_q, cnt_d;
    logic             ign_q, ign_d;         // ignoring a frame until i_v falls
    logic             prev_v_q, prev_v_d;   // i_v seen on the previous ce
    logic             drop_q, drop_d;
    logic             rise;

    assign rise = bus.i_v & ~prev_v_q;

    // Next-state, delay line and output register updates.
    always_comb begin
        state_d  = state_q;
        line_v_d = line_v_q;
        line_d_d = line_d_q;
        ov_d     = ov_q;
        od_d     = od_q;
        bypass_d = bypass_q;
        cnt_d    = cnt_q;
        ign_d    = ign_q;
        prev_v_d = prev_v_q;
        drop_d   = 1'b0;

        if (bus.i_ce) begin
            prev_v_d = bus.i_v;
            if (!bus.i_v) begin
                ign_d = 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.i_v && !ign_q) begin
                        if (bus.i_cancel) begin
                            ign_d = 1'b1;
                        end else begin
                            bypass_d = ~bus.i_en;
                            state_d  = StFrame;
                            ov_d     = 1'b1;
                            if (bus.i_en) begin
                                od_d     = 4'h5;
                                line_v_d = 16'hffff;
                                line_d_d = {bus.i_d, 4'hd, {14{4'h5}}};
                            end else begin
                                od_d = bus.i_d;
                            end
                        end
                    end
                end

                StFrame: begin
                    if (bus.i_cancel) begin
                        line_v_d = '0;
                        ov_d     = 1'b0;
                        od_d     = 4'h0;
                        state_d  = StGap;
                        cnt_d    = GapFull;
                        ign_d    = bus.i_v;
                    end else if (bypass_q) begin
                        ov_d = bus.i_v;
                        od_d = bus.i_v ? bus.i_d : 4'h0;
                        if (!bus.i_v) begin
                            state_d = StGap;
                            cnt_d   = GapShort;
                        end
                    end else begin
                        line_v_d = {bus.i_v, line_v_q[15:1]};
                        line_d_d = {bus.i_d, line_d_q[63:4]};
                        ov_d     = line_v_q[0];
                        od_d     = line_d_q[3:0];
                        if (!bus.i_v) begin
                            state_d = StDrain;
                        end
                    end
                end

                StDrain: begin
                    if (bus.i_cancel) begin
                        line_v_d = '0;
                        ov_d     = 1'b0;
                        od_d     = 4'h0;
                        state_d  = StGap;
                        cnt_d    = GapFull;
                        ign_d    = bus.i_v;
                    end else begin
                        if (rise) begin
                            drop_d = 1'b1;
                            ign_d  = 1'b1;
                        end
                        line_v_d = {1'b0, line_v_q[15:1]};
                        line_d_d = {4'h0, line_d_q[63:4]};
                        ov_d     = line_v_q[0];
                        od_d     = line_d_q[3:0];
                        // Entry 0 is the last valid one: it goes out on this edge.
                        if (!line_v_q[1]) begin
                            state_d = StGap;
                            cnt_d   = GapFull;
                        end
                    end
                end

                StGap: begin
                    if (rise) begin
                        drop_d = 1'b1;
                        ign_d  = 1'b1;
                    end
                    ov_d = 1'b0;
                    od_d = 4'h0;
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            line_v_q <= '0;
            line_d_q <= '0;
            ov_q     <= 1'b0;
            od_q     <= 4'h0;
            bypass_q <= 1'b0;
            cnt_q    <= '0;
            ign_q    <= 1'b0;
            prev_v_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_v_q <= line_v_d;
            line_d_q <= line_d_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            bypass_q <= bypass_d;
            cnt_q    <= cnt_d;
            ign_q    <= ign_d;
            prev_v_q <= prev_v_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.o_v    = ov_q;
    assign bus.o_d    = od_q;
    assign bus.o_busy = (state_q != StIdle);
    assign bus.o_drop = drop_q;

endmodule

// File: tb/tb_addepreamble.sv
// Directed bench for addepreamble: preamble insertion, slow ce, rejected
// starts, cancel, bypass and asynchronous reset.
module tb_addepreamble;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    addepreamble_if bus ();

    addepreamble #(
        .IFG_NIBBLES (24),
        .LGIFG       (5)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] b4(input logic b);
        return {3'b000, b};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [3:0] obs,
                       input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Expected o_d after ce edge j of a preamble frame whose data starts at d0.
    function automatic logic [3:0] exp_pre(input logic [3:0] d0, input int j);
        if (j < 15) return 4'h5;
        if (j == 15) return 4'hd;
        return d0 + 4'(j - 16);
    endfunction

    // 4-nibble preamble frame d0..d0+3 from IDLE, ce every div clocks,
    // followed by the full gap.
    task automatic pre_frame(input string tag, input logic [3:0] d0, input int div);
        for (int j = 0; j < 46; j++) begin
            for (int c = 0; c < div; c++) begin
                bus.i_ce = (c == 0);
                bus.i_v  = (j < 4);
                bus.i_d  = d0 + 4'(j);
                clk1();
                chk({tag, "_v"}, j, b4(bus.o_v), b4(j < 20));
                if (j < 20) chk({tag, "_d"}, j, bus.o_d, exp_pre(d0, j));
                chk({tag, "_busy"}, j, b4(bus.o_busy), b4(j < 43));
                chk({tag, "_drop"}, j, b4(bus.o_drop), 4'h0);
            end
        end
        bus.i_ce = 1'b1;
        bus.i_v  = 1'b0;
    endtask

    initial begin
        bus.i_ce     = 1'b1;
        bus.i_en     = 1'b1;
        bus.i_cancel = 1'b0;
        bus.i_v      = 1'b0;
        bus.i_d      = 4'h0;

        // Reset values
        #12;
        chk("rst_v", 0, b4(bus.o_v), 4'h0);
        chk("rst_d", 0, bus.o_d, 4'h0);
        chk("rst_busy", 0, b4(bus.o_busy), 4'h0);
        chk("rst_drop", 0, b4(bus.o_drop), 4'h0);
        clk1();
        rst_n = 1'b1;
        clk1();

        // Basic frame, ce every clock, then every third clock
        pre_frame("t1", 4'h1, 1);
        pre_frame("t2", 4'h1, 3);

        // Second frame starts 10 ce cycles into the gap: dropped
        for (int i = 0; i < 46; i++) begin
            bus.i_v = (i < 4) || (i >= 29 && i < 33);
            bus.i_d = (i < 4) ? 4'(i + 1) : 4'hf;
            clk1();
            chk("t3_v", i, b4(bus.o_v), b4(i < 20));
            if (i < 20) chk("t3_d", i, bus.o_d, exp_pre(4'h1, i));
            chk("t3_drop", i, b4(bus.o_drop), b4(i == 29));
            chk("t3_busy", i, b4(bus.o_busy), b4(i < 43));
        end
        bus.i_v = 1'b0;
        pre_frame("t3b", 4'h9, 1);

        // Cancel at ce index 8 of a 40-nibble frame
        for (int i = 0; i < 42; i++) begin
            bus.i_v      = (i < 40);
            bus.i_cancel = (i == 8);
            bus.i_d      = 4'(i);
            clk1();
            chk("t4_v", i, b4(bus.o_v), b4(i < 8));
            if (i < 8) chk("t4_d", i, bus.o_d, 4'h5);
            chk("t4_busy", i, b4(bus.o_busy), b4(i < 32));
            chk("t4_drop", i, b4(bus.o_drop), 4'h0);
        end
        bus.i_cancel = 1'b0;
        bus.i_v      = 1'b0;
        pre_frame("t4b", 4'h2, 1);

        // Start and cancel together in IDLE: frame ignored, no drop
        for (int i = 0; i < 6; i++) begin
            bus.i_v      = (i < 4);
            bus.i_cancel = (i == 0);
            bus.i_d      = 4'h7;
            clk1();
            chk("t5_v", i, b4(bus.o_v), 4'h0);
            chk("t5_busy", i, b4(bus.o_busy), 4'h0);
            chk("t5_drop", i, b4(bus.o_drop), 4'h0);
        end
        bus.i_cancel = 1'b0;
        pre_frame("t5b", 4'h4, 1);

        // Bypass: A,B,C with one ce latency, 24-cycle gap
        bus.i_en = 1'b0;
        for (int i = 0; i < 29; i++) begin
            bus.i_v = (i < 3);
            bus.i_d = 4'(10 + i);
            clk1();
            chk("t6_v", i, b4(bus.o_v), b4(i < 3));
            if (i < 3) chk("t6_d", i, bus.o_d, 4'(10 + i));
            chk("t6_busy", i, b4(bus.o_busy), b4(i < 26));
        end
        bus.i_en = 1'b1;
        bus.i_v  = 1'b0;

        // Asynchronous reset after the 7th preamble nibble
        for (int i = 0; i < 7; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = 4'(i + 1);
            clk1();
            chk("t7_v", i, b4(bus.o_v), 4'h1);
            chk("t7_d", i, bus.o_d, 4'h5);
        end
        #2;
        rst_n   = 1'b0;
        bus.i_v = 1'b0;
        #1;
        chk("t7_rst_v", 0, b4(bus.o_v), 4'h0);
        chk("t7_rst_d", 0, bus.o_d, 4'h0);
        chk("t7_rst_busy", 0, b4(bus.o_busy), 4'h0);
        clk1();
        rst_n = 1'b1;
        clk1();
        pre_frame("t7b", 4'h3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
